// File: rtl/vip_slink_sched_pkg.sv
// Shared types and default sizes for the serial-link session scheduler.
// Imported by the interface, the picker and the scheduler top.
package vip_slink_sched_pkg;

  localparam int unsigned DefNumPorts  = 4;
  localparam int unsigned DefCntWidth  = 16;
  localparam int unsigned DefStatWidth = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } sched_state_e;

  typedef logic [$clog2(DefNumPorts)-1:0] port_idx_t;
  typedef logic [DefCntWidth-1:0]         hold_cnt_t;
  typedef logic [DefStatWidth-1:0]        stat_cnt_t;

endpackage

// File: rtl/vip_slink_port_scheduler_if.sv
// Request/grant bundle between the virtual AXI requesters and the session scheduler.
// The scheduler uses the slave view; the requester side uses the master view.
interface vip_slink_port_scheduler_if
  import vip_slink_sched_pkg::*;
#(
  parameter int unsigned NumPorts = DefNumPorts,
  parameter int unsigned IdxWidth = $clog2(NumPorts)
);

  logic [NumPorts-1:0] req_i;
  logic [NumPorts-1:0] done_i;
  logic [NumPorts-1:0] gnt_o;
  logic [IdxWidth-1:0] owner_o;
  logic                busy_o;
  logic                timeout_o;

  modport master (
    output req_i,
    output done_i,
    input  gnt_o,
    input  owner_o,
    input  busy_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  done_i,
    output gnt_o,
    output owner_o,
    output busy_o,
    output timeout_o
  );

endinterface

// File: rtl/vip_slink_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i,
// wrapping around the port count.
module vip_slink_rr_pick #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxWidth = $clog2(NumPorts)
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  int unsigned cand;

  // Walk the ports starting at the pointer; the first hit wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cand = (int'(ptr_i) + i) % NumPorts;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/vip_slink_port_scheduler.sv
// Session-level round-robin owner of the shared serial-link path: one requester at a
// time, released on done, withdrawal or hold-time limit, with per-port grant statistics.
module vip_slink_port_scheduler
  import vip_slink_sched_pkg::*;
#(
  parameter int unsigned NumPorts  = DefNumPorts,
  parameter int unsigned CntWidth  = DefCntWidth,
  parameter int unsigned StatWidth = DefStatWidth,
  parameter int unsigned IdxWidth  = $clog2(NumPorts)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               en_i,
  input  logic [CntWidth-1:0]                hold_limit_i,
  input  logic                               clr_stats_i,
  output logic [NumPorts-1:0][StatWidth-1:0] grant_cnt_o,
  vip_slink_port_scheduler_if.slave          port_if
);

  sched_state_e state_q, state_d;

  logic [IdxWidth-1:0] owner_q, owner_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] pick_idx;
  logic                pick_valid;

  logic [CntWidth-1:0] hold_cnt_q, hold_cnt_d;

  logic [NumPorts-1:0] gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic                grant_fire;

  logic                sess_end;
  logic                limit_hit;

  logic [NumPorts-1:0][StatWidth-1:0] grant_cnt_q;

  function automatic logic [NumPorts-1:0] to_onehot(input logic [IdxWidth-1:0] idx);
    logic [NumPorts-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
    return (idx == IdxWidth'(NumPorts - 1)) ? '0 : idx + IdxWidth'(1);
  endfunction

  vip_slink_rr_pick #(
    .NumPorts (NumPorts),
    .IdxWidth (IdxWidth)
  ) u_rr_pick (
    .req_i   (port_if.req_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Done or withdrawal outranks the limit, which is what suppresses the timeout pulse.
  assign sess_end  = port_if.done_i[owner_q] | ~port_if.req_i[owner_q];
  assign limit_hit = (hold_limit_i != '0) && (hold_cnt_q == hold_limit_i - CntWidth'(1));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = '0;
    busy_d     = 1'b0;
    timeout_d  = 1'b0;
    grant_fire = 1'b0;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (en_i && pick_valid) begin
          state_d    = ST_GRANT;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
          gnt_d      = to_onehot(pick_idx);
          busy_d     = 1'b1;
          grant_fire = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (sess_end || limit_hit) begin
          state_d   = ST_RELEASE;
          rr_ptr_d  = next_idx(owner_q);
          timeout_d = limit_hit & ~sess_end;
        end else begin
          hold_cnt_d = hold_cnt_q + CntWidth'(1);
          gnt_d      = to_onehot(owner_q);
          busy_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  // A clear in the same cycle as a grant leaves the winner's counter at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_q <= '0;
    end else if (clr_stats_i) begin
      grant_cnt_q <= '0;
    end else if (grant_fire && (grant_cnt_q[pick_idx] != '1)) begin
      grant_cnt_q[pick_idx] <= grant_cnt_q[pick_idx] + StatWidth'(1);
    end
  end

  assign port_if.gnt_o     = gnt_q;
  assign port_if.owner_o   = owner_q;
  assign port_if.busy_o    = busy_q;
  assign port_if.timeout_o = timeout_q;
  assign grant_cnt_o       = grant_cnt_q;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_q));

  a_gnt_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (gnt_q != '0) == busy_q);

  a_no_handover_without_bubble : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((gnt_q != '0) && ($past(gnt_q) != '0)) |-> (gnt_q == $past(gnt_q)));

endmodule

// File: tb/tb_vip_slink_port_scheduler.sv
// Scoreboard bench for the session scheduler: directed test-plan sequences followed by
// random traffic, all predicted by a cycle-level behavioural model of the scheduling rules.
module tb_vip_slink_port_scheduler;

  localparam int NP = 4;
  localparam int CW = 16;
  localparam int SW = 4;
  localparam int IW = $clog2(NP);

  typedef struct {
    int                      cyc;
    logic [NP-1:0]           gnt;
    logic                    busy;
    logic                    tmo;
    int                      owner;
    logic [NP-1:0][SW-1:0]   cnt;
  } exp_t;

  logic                      clk;
  logic                      rst_ni;
  logic                      en;
  logic [CW-1:0]             hold_limit;
  logic                      clr_stats;
  logic [NP-1:0][SW-1:0]     grant_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc_now  = 0;

  exp_t sb_q[$];

  // Reference model: who holds the path, for how long, and whose turn is next.
  bit m_active;
  int m_owner;
  int m_ptr;
  int m_len;
  bit m_tmo;
  int m_cnt[NP];

  vip_slink_port_scheduler_if #(.NumPorts(NP)) port_if ();

  vip_slink_port_scheduler #(
    .NumPorts  (NP),
    .CntWidth  (CW),
    .StatWidth (SW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .en_i         (en),
    .hold_limit_i (hold_limit),
    .clr_stats_i  (clr_stats),
    .grant_cnt_o  (grant_cnt),
    .port_if      (port_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_len    = 0;
    m_tmo    = 1'b0;
    foreach (m_cnt[p]) m_cnt[p] = 0;
  endtask

  task automatic model_step(input logic [NP-1:0] req, input logic [NP-1:0] done,
                            input logic en_v, input int lim, input logic clr);
    bit ended;
    bit hit;
    int p;
    m_tmo = 1'b0;
    if (m_active) begin
      ended = done[m_owner] || !req[m_owner];
      hit   = (lim != 0) && (m_len == lim - 1);
      if (ended || hit) begin
        m_active = 1'b0;
        m_ptr    = (m_owner + 1) % NP;
        m_tmo    = hit && !ended;
      end else begin
        m_len = (m_len + 1) % (1 << CW);
      end
    end else if (en_v && (req != '0)) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        if (req[p]) begin
          m_owner = p;
          break;
        end
      end
      m_active = 1'b1;
      m_len    = 0;
      if (m_cnt[m_owner] < (1 << SW) - 1) m_cnt[m_owner]++;
    end
    if (clr) foreach (m_cnt[q]) m_cnt[q] = 0;
  endtask

  task automatic push_expect(input int cyc);
    exp_t e;
    e.cyc   = cyc;
    e.gnt   = m_active ? NP'(1 << m_owner) : '0;
    e.busy  = m_active;
    e.tmo   = m_tmo;
    e.owner = m_owner;
    for (int p = 0; p < NP; p++) e.cnt[p] = SW'(m_cnt[p]);
    sb_q.push_back(e);
  endtask

  task automatic check_value(input string name, input int cyc,
                             input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_value("gnt",     e.cyc, 64'(port_if.gnt_o),     64'(e.gnt));
    check_value("busy",    e.cyc, 64'(port_if.busy_o),    64'(e.busy));
    check_value("timeout", e.cyc, 64'(port_if.timeout_o), 64'(e.tmo));
    if (e.busy) check_value("owner", e.cyc, 64'(port_if.owner_o), 64'(e.owner));
    check_value("grant_cnt", e.cyc, 64'(grant_cnt), 64'(e.cnt));
  endtask

  // Monitor: compare whatever the DUT shows against the prediction for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((sb_q.size() > 0) && (sb_q[0].cyc == cyc_now)) begin
        e = sb_q.pop_front();
        check_output(e);
      end
    end
  end

  task automatic apply_stimulus(input logic [NP-1:0] req, input logic [NP-1:0] done,
                                input logic en_v, input int lim, input logic clr,
                                input logic rst_n);
    @(posedge clk);
    #1;
    port_if.req_i  = req;
    port_if.done_i = done;
    en             = en_v;
    hold_limit     = CW'(lim);
    clr_stats      = clr;
    if (!rst_n) begin
      if (rst_ni) begin
        rst_ni = 1'b0;
        #1;
        check_value("async_rst_gnt",  cyc_now, 64'(port_if.gnt_o),  64'd0);
        check_value("async_rst_busy", cyc_now, 64'(port_if.busy_o), 64'd0);
        sb_q.delete();
        model_reset();
        push_expect(cyc_now);
      end
      model_reset();
      push_expect(cyc_now + 1);
    end else begin
      rst_ni = 1'b1;
      model_step(req, done, en_v, lim, clr);
      push_expect(cyc_now + 1);
    end
  endtask

  task automatic step(input logic [NP-1:0] req, input logic [NP-1:0] done,
                      input logic en_v, input int lim, input logic clr);
    apply_stimulus(req, done, en_v, lim, clr, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    repeat (cycles) apply_stimulus('0, '0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  logic [NP-1:0] req_r;
  logic [NP-1:0] done_r;
  int            lim_r;
  int            lim_tab[6] = '{0, 1, 2, 3, 5, 8};

  initial begin
    rst_ni         = 1'b0;
    en             = 1'b0;
    hold_limit     = '0;
    clr_stats      = 1'b0;
    port_if.req_i  = '0;
    port_if.done_i = '0;
    model_reset();

    do_reset(3);

    // Single requester, done on its tenth grant cycle.
    step(4'b0010, 4'b0000, 1'b1, 0, 1'b0);
    repeat (9) step(4'b0010, 4'b0000, 1'b1, 0, 1'b0);
    step(4'b0010, 4'b0010, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);

    // Fairness: everyone requesting, each session ends on its third cycle.
    do_reset(2);
    step(4'b1111, 4'b0000, 1'b1, 0, 1'b0);
    repeat (8) begin
      step(4'b1111, 4'b0000, 1'b1, 0, 1'b0);
      step(4'b1111, 4'b0000, 1'b1, 0, 1'b0);
      step(4'b1111, 4'b1111, 1'b1, 0, 1'b0);
      step(4'b1111, 4'b0000, 1'b1, 0, 1'b0);
    end
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);

    // Hold limit of 5 with a requester that never finishes.
    repeat (16) step(4'b0001, 4'b0000, 1'b1, 5, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);

    // Done coinciding with the limit.
    step(4'b0001, 4'b0000, 1'b1, 3, 1'b0);
    step(4'b0001, 4'b0000, 1'b1, 3, 1'b0);
    step(4'b0001, 4'b0000, 1'b1, 3, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 3, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);

    // Non-owner done ignored, then the owner withdraws.
    step(4'b0100, 4'b0000, 1'b1, 0, 1'b0);
    repeat (3) step(4'b0100, 4'b1011, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);

    // Enable low with requests pending, then enable dropped mid-grant.
    repeat (4) step(4'b1010, 4'b0000, 1'b0, 0, 1'b0);
    step(4'b1010, 4'b0000, 1'b1, 0, 1'b0);
    repeat (4) step(4'b1010, 4'b0000, 1'b0, 0, 1'b0);
    step(4'b1010, 4'b1010, 1'b0, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 0, 1'b0);

    // Reset mid-grant, then port 0 must win first.
    step(4'b1000, 4'b0000, 1'b1, 0, 1'b0);
    step(4'b1000, 4'b0000, 1'b1, 0, 1'b0);
    step(4'b1000, 4'b0000, 1'b1, 0, 1'b0);
    do_reset(2);
    repeat (4) step(4'b1111, 4'b0000, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);

    // Saturation of a 4-bit counter, then a clear overlapping an arbitration cycle.
    repeat (42) step(4'b0100, 4'b0100, 1'b1, 0, 1'b0);
    step(4'b0100, 4'b0100, 1'b1, 0, 1'b1);
    step(4'b0100, 4'b0100, 1'b1, 0, 1'b1);
    repeat (4) step(4'b0100, 4'b0100, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 0, 1'b0);

    // Random traffic.
    req_r = '0;
    lim_r = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < NP; b++) begin
        if ($urandom_range(0, 9) == 0) req_r[b] = ~req_r[b];
        done_r[b] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 49) == 0) lim_r = lim_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
      end else begin
        step(req_r, done_r, ($urandom_range(0, 9) != 0), lim_r,
             ($urandom_range(0, 99) == 0));
      end
    end

    step('0, '0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vip_slink_port_scheduler.md
# vip_slink_port_scheduler

Session-level round-robin scheduler for the virtual external AXI requesters that share the multiplexed serial-link path in the Carfield SoC verification environment. Each requester asks for exclusive ownership of the shared path, holds it for a whole session, and releases it on its own or on a programmable hold-time limit. The block sits in front of the AXI multiplexer and the ID remapper. Its grant vector gates the testbench drivers, so only one virtual port issues traffic at a time. It also keeps per-port grant statistics.

## Interface
- NumPorts, 4: number of requesters; equals the external AXI slave port count; must be ≥2.
- CntWidth, 16: width of the hold counter and the hold limit.
- StatWidth, 16: width of each per-port grant counter.
- IdxWidth, $clog2(NumPorts): derived; do not override.
- clk_i  in  1  system clock; one clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- en_i  in  1  arbitration enable; gates new grants only.
- req_i  in  NumPorts  level session request per port.
- done_i  in  NumPorts  end-of-session pulse; only the owner's bit is honoured.
- hold_limit_i  in  CntWidth  maximum grant length in cycles; 0 = unlimited.
- clr_stats_i  in  1  synchronous clear of the grant counters.
- gnt_o  out  NumPorts  one-hot grant, or all-zero.
- owner_o  out  IdxWidth  index of the current owner; valid while busy_o is high.
- busy_o  out  1  a grant is active.
- timeout_o  out  1  single-cycle pulse: the owner was revoked by the hold limit.
- grant_cnt_o  out  NumPorts×StatWidth  saturating count of grants per port.

## Operation
- FSM states: IDLE, GRANT, RELEASE. All outputs are registered.
- Arbitration in IDLE or RELEASE:
  - Runs when en_i=1 and at least one bit of req_i is set.
  - Picks the first set bit of req_i at or above rr_ptr, wrapping modulo NumPorts.
  - Registers the winner into owner and moves to GRANT.
  - Increments grant_cnt[winner], saturating at all-ones.
- Otherwise RELEASE moves to IDLE, and IDLE stays in IDLE.
- GRANT:
  - gnt_o[owner]=1 and busy_o=1. hold_cnt starts at 0 on the first GRANT cycle and increments every cycle.
  - Exit to RELEASE when any of these holds:
    - done_i[owner]=1;
    - req_i[owner]=0 (withdrawal);
    - hold_limit_i≠0 and hold_cnt==hold_limit_i−1. This is the timeout case; timeout_o=1 during the following RELEASE cycle.
  - Simultaneous done/withdrawal and timeout: treated as done; no timeout pulse.
  - done_i bits of non-owners are ignored.
  - en_i has no effect while in GRANT.
  - A change of hold_limit_i mid-grant takes effect on the next compare. If the new limit is already below hold_cnt+1, the grant runs until done or counter wrap.
- On entry to RELEASE:
  - rr_ptr ← (owner+1) mod NumPorts, so the releasing port has the lowest priority next round.
  - gnt_o and busy_o are 0 for at least that cycle (drain bubble).
- clr_stats_i zeroes all grant counters. If it coincides with a grant, clear wins.
- Reset state:
  - state=IDLE, rr_ptr=0, owner=0, hold_cnt=0, all counters 0.
  - gnt_o=0, owner_o=0, busy_o=0, timeout_o=0.
  - Assertion of rst_ni mid-grant drops gnt_o immediately (asynchronous).

## Timing
- req_i seen in IDLE at cycle t → gnt_o high from t+1.
- done_i at cycle g → gnt_o low at g+1 (RELEASE). The next owner's gnt_o is high at g+2 at the earliest.
- hold_limit_i=L → gnt_o is high for exactly L cycles. timeout_o pulses in the cycle after the last grant cycle.
- grant_cnt_o updates one cycle after the arbitration cycle, i.e. together with gnt_o rising.
- gnt_o is never high for two ports in the same cycle, or in two consecutive cycles for different owners.

## Structure
- Package vip_slink_sched_pkg holds:
  - the FSM state enum;
  - the typedefs for the port index, hold counter and stat counter;
  - the default NumPorts, CntWidth and StatWidth constants.
- Sub-module vip_slink_rr_pick is the combinational rotate-priority picker. Inputs: request vector and pointer. Outputs: winner index and valid.
- The top level holds the FSM, the hold counter, rr_ptr and the statistics counters.

## Test plan
- Single requester: req_i=4'b0010, L=0, done_i[1] pulsed at grant cycle 10.
  - gnt_o=0010 for 10 cycles, then one zero cycle.
  - grant_cnt[1]=1 and owner_o=1 throughout the grant.
- Fairness: all four ports requesting continuously, each pulsing done after 3 cycles.
  - Grant order is 0,1,2,3,0,…
  - There is one bubble cycle between grants, and every counter equals 2 after 8 grants.
- Timeout: req_i=0001, never done, L=5.
  - gnt_o is high for exactly 5 cycles and timeout_o pulses once.
  - Port 0 is re-granted after the bubble; port 0 requesting alone still wins after the wrap.
- Corner cases:
  - done and timeout in the same cycle → no timeout pulse.
  - done_i from a non-owner → ignored.
  - Owner withdraws req_i → release with no pulse.
  - en_i=0 while requests are pending → no grant.
  - en_i dropped mid-grant → the grant completes normally.
- Reset and saturation:
  - rst_ni asserted mid-grant → gnt_o is 0 in the same cycle; after release, port 0 wins first.
  - StatWidth=4 with 20 grants → the counter holds 15.
  - clr_stats_i coinciding with a grant → the counter reads 0.
